// File: rtl/shift_ctrl.sv
// shift_ctrl: clear/load/shift sequencer for an N-bit shift register.
// Optional rotate feedback on Shiftin when SHIFT_CTRL_ROTATE_EN is defined.
module shift_ctrl #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          CLK,
  input  logic          clr_n,
  input  logic          start,
  input  logic          clear_req,
  input  logic          abort,
  input  logic          dir,
  input  logic [CW-1:0] cnt,
  input  logic [N:1]    D_in,
  input  logic          sin,
  input  logic [N:1]    Qin,
`ifdef SHIFT_CTRL_ROTATE_EN
  input  logic          rot,
`endif
  output logic [N:1]    D_out,
  output logic          Ld,
  output logic          Sh,
  output logic          Lshift,
  output logic          Shiftin,
  output logic          sclr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CW-1:0] NMAX = CW'(N);

  state_t        state;
  logic [CW-1:0] ctr;
  logic [N:1]    word_q;
  logic          dir_q;
  logic [CW-1:0] cnt_clamp;
  logic          unused_qin;

  assign cnt_clamp = (cnt > NMAX) ? NMAX : cnt;

`ifdef SHIFT_CTRL_ROTATE_EN
  logic rot_q;
`endif

  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      ctr    <= '0;
      word_q <= '0;
      dir_q  <= 1'b0;
`ifdef SHIFT_CTRL_ROTATE_EN
      rot_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
          end else if (start) begin
            state  <= LOAD;
            word_q <= D_in;
            dir_q  <= dir;
            ctr    <= cnt_clamp;
`ifdef SHIFT_CTRL_ROTATE_EN
            rot_q  <= rot;
`endif
          end
        end
        CLEAR: state <= IDLE;
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            ctr   <= '0;
          end else if (ctr != '0) begin
            state <= SHIFT;
          end else begin
            state <= DONE;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            ctr   <= '0;
          end else begin
            // last Sh cycle is the one where ctr reaches 0
            ctr <= ctr - 1'b1;
            if (ctr == CW'(1)) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Ld     = (state == LOAD);
  assign Sh     = (state == SHIFT);
  assign sclr   = (state == CLEAR);
  assign done   = (state == DONE);
  assign busy   = (state == CLEAR) || Ld || Sh;
  assign D_out  = word_q;
  assign Lshift = dir_q;

  assign unused_qin = ^Qin;

`ifdef SHIFT_CTRL_ROTATE_EN
  assign Shiftin = rot_q ? (dir_q ? Qin[N] : Qin[1]) : sin;
`else
  assign Shiftin = sin;
`endif

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: scoreboard bench for shift_ctrl (N=4, CW=3).
// Expected per-cycle outputs are queued at stimulus time, popped on negedge.
module tb_shift_ctrl;
  localparam int N  = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          clr_n = 1'b0;
  logic          start = 1'b0;
  logic          clear_req = 1'b0;
  logic          abort = 1'b0;
  logic          dir = 1'b0;
  logic          sin = 1'b0;
  logic [CW-1:0] cnt = '0;
  logic [N:1]    D_in = '0;
  logic [N:1]    Qin = '0;
`ifdef SHIFT_CTRL_ROTATE_EN
  logic          rot = 1'b0;
`endif
  logic [N:1]    D_out;
  logic          Ld, Sh, Lshift, Shiftin, sclr, busy, done;

  typedef struct packed {
    logic       ld;
    logic       sh;
    logic       sc;
    logic       bz;
    logic       dn;
    logic       ls;
    logic [3:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 CLK = ~CLK;

  shift_ctrl #(.N(N), .CW(CW)) dut (
    .CLK(CLK), .clr_n(clr_n), .start(start),
    .clear_req(clear_req), .abort(abort), .dir(dir),
    .cnt(cnt), .D_in(D_in), .sin(sin), .Qin(Qin),
`ifdef SHIFT_CTRL_ROTATE_EN
    .rot(rot),
`endif
    .D_out(D_out), .Ld(Ld), .Sh(Sh), .Lshift(Lshift),
    .Shiftin(Shiftin), .sclr(sclr), .busy(busy), .done(done)
  );

  function automatic exp_t obs();
    exp_t o;
    o = {Ld, Sh, sclr, busy, done, Lshift, D_out};
    return o;
  endfunction

  task automatic push(input logic ld, sh, sc, bz, dn, ls,
                      input logic [3:0] d);
    exp_t e;
    e = {ld, sh, sc, bz, dn, ls, d};
    sb.push_back(e);
  endtask

  // issue a command at this negedge and queue its expected trace
  task automatic issue(input logic [3:0] w, input logic dr,
                       input logic [CW-1:0] c);
    int n;
    D_in  = w;
    dir   = dr;
    cnt   = c;
    start = 1'b1;
    n = (c > 3'(N)) ? N : int'(c);
    push(1, 0, 0, 1, 0, dr, w);
    repeat (n) push(0, 1, 0, 1, 0, dr, w);
    push(0, 0, 0, 0, 1, dr, w);
    push(0, 0, 0, 0, 0, dr, w);
  endtask

  task automatic test_reset();
    exp_t o;
    #2;
    o = obs();
    checks++;
    if (o !== '0) $display("FAIL reset: got %b want %b", o, 10'b0);
    else passed++;
    checks++;
    if (Shiftin !== 1'b0) $display("FAIL reset_shiftin: got %b want 0", Shiftin);
    else passed++;
    @(negedge CLK);
    clr_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e, o;
    int i = 0;
    @(negedge CLK);
    issue(4'b1011, 1'b1, 3'd2);
    while (sb.size() > 0) begin
      @(negedge CLK);
      start = 1'b0;
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("FAIL basic c%0d: got %b want %b", i, o, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_cnt_zero();
    exp_t e, o;
    int i = 0;
    @(negedge CLK);
    issue(4'b0110, 1'b0, 3'd0);
    while (sb.size() > 0) begin
      @(negedge CLK);
      start = 1'b0;
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("FAIL cnt0 c%0d: got %b want %b", i, o, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_clamp();
    exp_t e, o;
    int i = 0;
    @(negedge CLK);
    issue(4'b1100, 1'b1, 3'd7);
    while (sb.size() > 0) begin
      @(negedge CLK);
      start = 1'b0;
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("FAIL clamp c%0d: got %b want %b", i, o, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_clear_wins();
    exp_t e, o;
    int i = 0;
    @(negedge CLK);
    D_in = 4'b0001;
    dir = 1'b0;
    cnt = 3'd1;
    start = 1'b1;
    clear_req = 1'b1;
    push(0, 0, 1, 1, 0, 1, 4'b1100);
    push(0, 0, 0, 0, 0, 1, 4'b1100);
    while (sb.size() > 0) begin
      @(negedge CLK);
      start = 1'b0;
      clear_req = 1'b0;
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("FAIL clear c%0d: got %b want %b", i, o, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_abort();
    exp_t e, o;
    int i = 0;
    @(negedge CLK);
    D_in = 4'b0101;
    dir = 1'b0;
    cnt = 3'd3;
    start = 1'b1;
    push(1, 0, 0, 1, 0, 0, 4'b0101);
    push(0, 1, 0, 1, 0, 0, 4'b0101);
    push(0, 1, 0, 1, 0, 0, 4'b0101);
    push(0, 0, 0, 0, 0, 0, 4'b0101);
    push(0, 0, 0, 0, 0, 0, 4'b0101);
    while (sb.size() > 0) begin
      @(negedge CLK);
      start = 1'b0;
      abort = (i == 2);
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("FAIL abort c%0d: got %b want %b", i, o, e);
      else passed++;
      i++;
    end
    abort = 1'b0;
    i = 0;
    issue(4'b1001, 1'b1, 3'd1);
    while (sb.size() > 0) begin
      @(negedge CLK);
      start = 1'b0;
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("FAIL post_abort c%0d: got %b want %b", i, o, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_done_ignore();
    exp_t e, o;
    int i = 0;
    @(negedge CLK);
    D_in = 4'b0011;
    dir = 1'b0;
    cnt = 3'd0;
    start = 1'b1;
    push(1, 0, 0, 1, 0, 0, 4'b0011);
    push(0, 0, 0, 0, 1, 0, 4'b0011);
    push(0, 0, 0, 0, 0, 0, 4'b0011);
    push(0, 0, 0, 0, 0, 0, 4'b0011);
    while (sb.size() > 0) begin
      @(negedge CLK);
      start = (i == 1);
      clear_req = (i == 1);
      D_in = 4'b1110;
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("FAIL done_ign c%0d: got %b want %b", i, o, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    int i = 0;
    @(negedge CLK);
    D_in = 4'b1111;
    dir = 1'b1;
    cnt = 3'd3;
    start = 1'b1;
    push(1, 0, 0, 1, 0, 1, 4'b1111);
    push(0, 1, 0, 1, 0, 1, 4'b1111);
    while (sb.size() > 0) begin
      @(negedge CLK);
      start = 1'b0;
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("FAIL arst_pre c%0d: got %b want %b", i, o, e);
      else passed++;
      i++;
    end
    #2 clr_n = 1'b0;
    #1 o = obs();
    checks++;
    if (o !== '0) $display("FAIL arst_now: got %b want %b", o, 10'b0);
    else passed++;
    @(negedge CLK);
    o = obs();
    checks++;
    if (o !== '0) $display("FAIL arst_held: got %b want %b", o, 10'b0);
    else passed++;
    clr_n = 1'b1;
    i = 0;
    issue(4'b0010, 1'b0, 3'd1);
    while (sb.size() > 0) begin
      @(negedge CLK);
      start = 1'b0;
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("FAIL arst_post c%0d: got %b want %b", i, o, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_shiftin();
    sin = 1'b1;
    Qin = 4'b0000;
    #1;
    checks++;
    if (Shiftin !== 1'b1) $display("FAIL sin1: got %b want 1", Shiftin);
    else passed++;
    sin = 1'b0;
    Qin = 4'b1001;
    #1;
    checks++;
    if (Shiftin !== 1'b0) $display("FAIL sin0: got %b want 0", Shiftin);
    else passed++;
`ifdef SHIFT_CTRL_ROTATE_EN
    @(negedge CLK);
    rot = 1'b1;
    D_in = 4'b0000;
    dir = 1'b0;
    cnt = 3'd0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    Qin = 4'b0001;
    #1;
    checks++;
    if (Shiftin !== 1'b1) $display("FAIL rot_r: got %b want 1", Shiftin);
    else passed++;
    Qin = 4'b1110;
    #1;
    checks++;
    if (Shiftin !== 1'b0) $display("FAIL rot_r0: got %b want 0", Shiftin);
    else passed++;
    @(negedge CLK);
    dir = 1'b1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    Qin = 4'b1000;
    #1;
    checks++;
    if (Shiftin !== 1'b1) $display("FAIL rot_l: got %b want 1", Shiftin);
    else passed++;
    @(negedge CLK);
    rot = 1'b0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    sin = 1'b0;
    #1;
    checks++;
    if (Shiftin !== 1'b0) $display("FAIL rot_off: got %b want 0", Shiftin);
    else passed++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_cnt_zero();
    test_clamp();
    test_clear_wins();
    test_abort();
    test_done_ignore();
    test_async_reset();
    test_shiftin();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
